// File: rtl/fetch_ir_unit_if.sv
// Bus bundle for the fetch/IR stage: instruction-memory read port,
// IR delivery handshake towards the decoder, PC redirect and IR fields.
interface fetch_ir_unit_if;
   logic        MEM_REQ;
   logic [15:0] MEM_ADDR;
   logic [15:0] MEM_RDATA;
   logic        MEM_ACK;
   logic        IR_VALID;
   logic        IR_TAKEN;
   logic        PC_LOAD;
   logic [15:0] PC_NEXT;
   logic [15:0] PC;
   logic [15:0] IR;
   logic [3:0]  OPCODE;
   logic [3:0]  RD;
   logic [3:0]  RS;
   logic [3:0]  IMM4;

   // The fetch unit drives memory requests and the IR side.
   modport master (
      output MEM_REQ, MEM_ADDR, IR_VALID, PC, IR, OPCODE, RD, RS, IMM4,
      input  MEM_RDATA, MEM_ACK, IR_TAKEN, PC_LOAD, PC_NEXT
   );

   // Memory plus decoder side of the same bundle.
   modport slave (
      input  MEM_REQ, MEM_ADDR, IR_VALID, PC, IR, OPCODE, RD, RS, IMM4,
      output MEM_RDATA, MEM_ACK, IR_TAKEN, PC_LOAD, PC_NEXT
   );
endinterface

// File: rtl/fetch_ir_unit.sv
// Instruction fetch / instruction register stage of the 16-bit multicycle
// datapath. Owns the PC, reads instruction words over a req/ack port and
// hands them to the decoder through a valid/taken handshake.
module fetch_ir_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned PC_STEP  = 1
) (
   input logic             CLK,
   input logic             RESET_N,
   fetch_ir_unit_if.master bus
);

   localparam logic [15:0] STEP = 16'(PC_STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

   state_t      state_reg;
   logic [15:0] pc_reg;
   logic [15:0] ir_reg;
   logic        mem_req_reg;
   logic        ir_valid_reg;

   // Fetch FSM with registered request/valid outputs; a redirect always
   // wins over an ack or an IR_TAKEN and restarts the fetch at the new PC.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_reg    <= IDLE;
         pc_reg       <= RESET_PC;
         ir_reg       <= 16'h0000;
         mem_req_reg  <= 1'b0;
         ir_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.PC_LOAD) begin
                  pc_reg <= bus.PC_NEXT;
               end
               state_reg   <= FETCH;
               mem_req_reg <= 1'b1;
            end
            FETCH, WAIT: begin
               if (bus.PC_LOAD) begin
                  // Abandon the outstanding read; any data returned now is dropped.
                  pc_reg      <= bus.PC_NEXT;
                  state_reg   <= FETCH;
                  mem_req_reg <= 1'b1;
               end else if (bus.MEM_ACK) begin
                  ir_reg       <= bus.MEM_RDATA;
                  pc_reg       <= pc_reg + STEP;
                  state_reg    <= VALID;
                  mem_req_reg  <= 1'b0;
                  ir_valid_reg <= 1'b1;
               end else begin
                  state_reg   <= WAIT;
                  mem_req_reg <= 1'b1;
               end
            end
            VALID: begin
               if (bus.PC_LOAD) begin
                  // Flush the IR even when the decoder also took it.
                  pc_reg       <= bus.PC_NEXT;
                  ir_valid_reg <= 1'b0;
                  state_reg    <= FETCH;
                  mem_req_reg  <= 1'b1;
               end else if (bus.IR_TAKEN) begin
                  ir_valid_reg <= 1'b0;
                  state_reg    <= FETCH;
                  mem_req_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg    <= IDLE;
               mem_req_reg  <= 1'b0;
               ir_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.MEM_REQ  = mem_req_reg;
   assign bus.MEM_ADDR = pc_reg;
   assign bus.PC       = pc_reg;
   assign bus.IR       = ir_reg;
   assign bus.IR_VALID = ir_valid_reg;
   assign bus.OPCODE   = ir_reg[15:12];
   assign bus.RD       = ir_reg[11:8];
   assign bus.RS       = ir_reg[7:4];
   assign bus.IMM4     = ir_reg[3:0];

endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
- Instruction fetch and instruction-register stage of the 16-bit multicycle datapath.
- Owns the PC and issues word reads to instruction memory with a req/ack handshake.
- Latches each returned word into the IR and presents it to the decoder with a valid/taken handshake.
- Splits the IR into fixed 4-bit fields. IMM4 feeds the 4-to-16 zero-extender directly.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetched word (word-addressed memory).

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  synchronous active-low reset
- MEM_REQ  output  1  read request to instruction memory
- MEM_ADDR  output  16  read address; always equals PC
- MEM_RDATA  input  16  read data; valid only when MEM_ACK=1
- MEM_ACK  input  1  one-cycle read-complete strobe
- IR_VALID  output  1  IR holds an undelivered instruction
- IR_TAKEN  input  1  decoder consumes the IR this cycle; ignored unless IR_VALID=1
- PC_LOAD  input  1  redirect request (branch/jump)
- PC_NEXT  input  16  redirect target
- PC  output  16  current fetch PC
- IR  output  16  instruction register
- OPCODE  output  4  IR[15:12]
- RD  output  4  IR[11:8]
- RS  output  4  IR[7:4]
- IMM4  output  4  IR[3:0]

Behaviour:
- Reset: one clock cycle with RESET_N=0 forces the following; it has priority over every other input, including mid-wait.
  - PC=RESET_PC, IR=16'h0000, IR_VALID=0, MEM_REQ=0, state IDLE.
  - Any pending ack is forgotten.
- Field outputs are combinational slices of IR. They are 0 after reset.
- FSM states and transitions:
  - IDLE: MEM_REQ=0. Always goes to FETCH next cycle. This gives one bubble after reset.
  - FETCH: MEM_REQ=1, MEM_ADDR=PC.
    - MEM_ACK=1 in the same cycle: IR<=MEM_RDATA, PC<=PC+PC_STEP, go VALID.
    - Otherwise go WAIT.
  - WAIT: MEM_REQ=1, held until MEM_ACK. On ack, same update as FETCH.
  - VALID: IR_VALID=1, MEM_REQ=0, IR stable.
    - IR_TAKEN=1: go FETCH next cycle.
    - IR_TAKEN=0: hold indefinitely.
- PC arithmetic is 16-bit modulo: 16'hFFFF + 1 wraps to 16'h0000 with no flag.
- Fetch latency: request cycle to IR_VALID=1 is (ack cycle − request cycle) + 1. Zero-wait memory gives IR_VALID the cycle after FETCH.
- Throughput with zero-wait memory is one instruction per 2 cycles (FETCH, VALID).
- PC_LOAD has priority over the PC increment in every state. Effects by state:
  - IDLE: PC<=PC_NEXT.
  - FETCH or WAIT with no ack: PC<=PC_NEXT, go FETCH. The outstanding request is abandoned, and MEM_ADDR changes to the new PC next cycle.
  - FETCH or WAIT with MEM_ACK=1 in the same cycle: the returned data is discarded (IR unchanged, IR_VALID stays 0), PC<=PC_NEXT, go FETCH.
  - VALID: PC<=PC_NEXT, IR_VALID<=0, go FETCH. The IR is flushed even if IR_TAKEN=1 the same cycle; the decoder must not commit a taken instruction when it also asserts PC_LOAD.
- MEM_ACK is ignored outside FETCH/WAIT.
- IR changes only on an accepted ack.
- MEM_ADDR equals PC in all states. Memory may only sample it when MEM_REQ=1.

Test Plan:
- Reset then zero-wait memory returning 16'h1234 at address 0 → IR_VALID=1 two cycles after reset release. OPCODE=1, RD=2, RS=3, IMM4=4, PC=1.
- Memory with 3 wait cycles, data 16'hA00F → MEM_REQ held 4 cycles at address 0, then IR=16'hA00F and IMM4=4'hF. The zero-extender downstream shows 16'h000F.
- IR_TAKEN held 0 for 5 cycles in VALID → IR, PC and IR_VALID stable. MEM_REQ=0 throughout. After IR_TAKEN=1, the next fetch uses address 1.
- PC_LOAD with PC_NEXT=16'h0040 in the same cycle as MEM_ACK with data 16'hFFFF → IR unchanged, IR_VALID stays 0, next MEM_ADDR=16'h0040.
- PC_LOAD to 16'hFFFF, fetch 16'h0001 → after ack PC=16'h0000 (wrap), IR=16'h0001.
- RESET_N=0 for one cycle during WAIT at PC=16'h0007 → next cycle PC=RESET_PC, MEM_REQ=0, IR=0, IR_VALID=0. A late MEM_ACK arriving after reset is ignored.
